// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The structs describe one command and one response at the default tag width.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    localparam int ALU_TAG_W  = 4;
    localparam int RSP_DEPTH  = 4;
    localparam int RSP_CNT_W  = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        alu_op_e              op;
        logic [ALU_TAG_W-1:0] tag;
    } alu_cmd_t;

    typedef struct packed {
        logic [8:0]           data;
        logic [ALU_TAG_W-1:0] tag;
    } alu_rsp_t;

    // A command may issue only while every result it could produce still has a
    // guaranteed slot: stage 1, stage 2 and the response FIFO together.
    function automatic logic credit_ok(input logic v1, input logic v2,
                                       input logic [RSP_CNT_W-1:0] rsp_count);
        return (int'(v1) + int'(v2) + int'(rsp_count)) < RSP_DEPTH;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response valid/ready streams of the ALU sequencer.
interface alu_sequencer_if
    import alu_pkg::*;
#(
    parameter int TAG_W = ALU_TAG_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    alu_op_e          cmd_op;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [8:0]       rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/alu_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head reads as zero while empty.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the empty flag masks stale words.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;

    // Upstream flow control must never offer a word the FIFO cannot hold.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/alu_sequencer.sv
// Buffers ALU commands, drives the registered ALU one command per cycle, and
// returns tagged results in order through a credit-protected response FIFO.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = ALU_TAG_W
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_sequencer_if.slave      bus,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [1:0]          alu_sel,
    input  logic [8:0]          alu_out,
    output logic                idle
);
    localparam int CMD_W = 8 + 8 + 2 + TAG_W;
    localparam int RSP_W = 9 + TAG_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CMD_W-1:0]     cmd_din;
    logic [CMD_W-1:0]     cmd_dout;
    logic [CNT_W-1:0]     cmd_count;
    logic                 cmd_full;
    logic                 cmd_empty;
    logic                 cmd_push;

    logic [7:0]           head_a;
    logic [7:0]           head_b;
    logic [1:0]           head_op;
    logic [TAG_W-1:0]     head_tag;

    logic [RSP_W-1:0]     rsp_din;
    logic [RSP_W-1:0]     rsp_dout;
    logic [RSP_CNT_W-1:0] rsp_count;
    logic                 rsp_valid;
    logic                 rsp_pop;

    logic                 issue;
    logic                 v1;
    logic                 v2;
    logic [TAG_W-1:0]     t1;
    logic [TAG_W-1:0]     t2;

    // Command side: ready depends only on FIFO state, never on issue or pop.
    assign cmd_full      = (cmd_count == CNT_W'(DEPTH));
    assign cmd_empty     = (cmd_count == '0);
    assign bus.cmd_ready = !cmd_full;
    assign cmd_push      = bus.cmd_valid && !cmd_full;
    assign cmd_din       = {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};

    alu_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (issue),
        .dout  (cmd_dout),
        .count (cmd_count)
    );

    assign head_a   = cmd_dout[CMD_W-1 -: 8];
    assign head_b   = cmd_dout[CMD_W-9 -: 8];
    assign head_op  = cmd_dout[TAG_W+1 -: 2];
    assign head_tag = cmd_dout[TAG_W-1:0];

    // Every term is a register, so rsp_ready has no combinational path to issue.
    assign issue = !cmd_empty && credit_ok(v1, v2, rsp_count);

    // NOTE: non-blocking assignments keep v2 <= v1 a true one-cycle shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            t1      <= '0;
            t2      <= '0;
        end else begin
            v1 <= issue;
            v2 <= v1;
            t2 <= t1;
            if (issue) begin
                alu_a   <= head_a;
                alu_b   <= head_b;
                alu_sel <= head_op;
                t1      <= head_tag;
            end
        end
    end

    // While v2 is set, alu_out carries the registered result for tag t2.
    assign rsp_din = {alu_out, t2};
    assign rsp_pop = rsp_valid && bus.rsp_ready;

    alu_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (v2),
        .din   (rsp_din),
        .pop   (rsp_pop),
        .dout  (rsp_dout),
        .count (rsp_count)
    );

    assign rsp_valid     = (rsp_count != '0);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_dout[RSP_W-1 -: 9];
    assign bus.rsp_tag   = rsp_dout[TAG_W-1:0];

    assign idle = cmd_empty && !v1 && !v2 && !rsp_valid;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with a behavioural ALU and
// a queue-based reference of expected responses in command order.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [8:0] alu_out;
    logic       idle;

    alu_sequencer_if #(.TAG_W(ALU_TAG_W)) bus ();

    alu_sequencer #(
        .DEPTH (4),
        .TAG_W (ALU_TAG_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    // External registered ALU: one cycle of latency, 9-bit result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= '0;
        else begin
            case (alu_sel)
                2'd0:    alu_out <= {1'b0, alu_a} + {1'b0, alu_b};
                2'd1:    alu_out <= {1'b0, alu_a} - {1'b0, alu_b};
                2'd2:    alu_out <= {1'b0, alu_a & alu_b};
                default: alu_out <= {1'b0, alu_a | alu_b};
            endcase
        end
    end

    alu_rsp_t model[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       pops     = 0;

    function automatic logic [8:0] ref_result(input int a, input int b, input int op);
        case (op)
            0:       return 9'((a + b) % 512);
            1:       return 9'((a - b + 512) % 512);
            2:       return 9'(a & b);
            default: return 9'(a | b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input int op, input logic [3:0] tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = alu_op_e'(op);
        bus.cmd_tag   = tag;
    endtask

    task automatic rand_cmd();
        set_cmd(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
    endtask

    // Called just after a falling edge: records the handshakes that the next
    // rising edge will complete, then advances to the following falling edge.
    task automatic cycle(output bit acc);
        alu_rsp_t e;
        acc = bus.cmd_valid && bus.cmd_ready;
        if (acc) begin
            e.data = ref_result(int'(bus.cmd_a), int'(bus.cmd_b), int'(bus.cmd_op));
            e.tag  = bus.cmd_tag;
            model.push_back(e);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            pops++;
            if (model.size() == 0) begin
                check("sb_unexpected_rsp", 32'(bus.rsp_tag), 32'hFFFF_FFFF);
            end else begin
                e = model.pop_front();
                check("sb_rsp_data", 32'(bus.rsp_data), 32'(e.data));
                check("sb_rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bit acc;
        int n = 0;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while ((model.size() != 0 || !idle) && n < 60) begin
            cycle(acc);
            n++;
        end
        check({tag, "_drained"}, 32'(model.size()), 0);
        check({tag, "_idle"}, 32'(idle), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int lat;
        int p0;
        int accepted;
        int n;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = ALU_ADD;
        bus.cmd_tag   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_rsp_tag", 32'(bus.rsp_tag), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single ADD with carry-out: FF + 01 = 0x100, three cycles after accept.
        bus.rsp_ready = 1'b1;
        set_cmd(8'hFF, 8'h01, 0, 4'd3);
        cycle(acc);
        check("add_accepted", 32'(acc), 1);
        check("idle_falls_on_accept", 32'(idle), 0);
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            cycle(acc);
            lat++;
        end
        check("add_latency", 32'(lat), 3);
        check("add_data", 32'(bus.rsp_data), 32'h100);
        check("add_tag", 32'(bus.rsp_tag), 3);
        cycle(acc);
        check("idle_rises_on_empty", 32'(idle), 1);
        check("rsp_valid_after_pop", 32'(bus.rsp_valid), 0);

        // Back-to-back SUB / AND / OR stream at full throughput.
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            case (i % 3)
                0:       set_cmd(8'd5, 8'd7, 1, 4'(i));
                1:       set_cmd(8'hF0, 8'h3C, 2, 4'(i));
                default: set_cmd(8'hF0, 8'h0F, 3, 4'(i));
            endcase
            check("b2b_cmd_ready", 32'(bus.cmd_ready), 1);
            cycle(acc);
        end
        bus.cmd_valid = 1'b0;
        repeat (4) cycle(acc);
        check("b2b_one_per_cycle", 32'(pops - p0), 8);
        check("b2b_idle", 32'(idle), 1);

        // Backpressure: 4 results outstanding plus 4 queued, then ready drops.
        bus.rsp_ready = 1'b0;
        p0 = pops;
        accepted = 0;
        rand_cmd();
        for (int c = 0; c < 20; c++) begin
            cycle(acc);
            if (acc) begin
                accepted++;
                rand_cmd();
            end
        end
        check("bp_accepted", 32'(accepted), 8);
        check("bp_cmd_ready_low", 32'(bus.cmd_ready), 0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        check("bp_no_pops", 32'(pops - p0), 0);
        check("bp_outstanding", 32'(model.size()), 8);

        // Full response FIFO: a single pop frees exactly one credit.
        p0 = pops;
        bus.rsp_ready = 1'b1;
        cycle(acc);
        bus.rsp_ready = 1'b0;
        check("full_single_pop", 32'(pops - p0), 1);
        check("full_no_accept", 32'(acc), 0);
        check("full_cmd_ready_low", 32'(bus.cmd_ready), 0);
        cycle(acc);
        check("issue_resumed", 32'(bus.cmd_ready), 1);
        check("resume_no_early_accept", 32'(acc), 0);

        bus.rsp_ready = 1'b1;
        n = 0;
        while (accepted < 12 && n < 60) begin
            cycle(acc);
            n++;
            if (acc) begin
                accepted++;
                if (accepted < 12) rand_cmd();
                else bus.cmd_valid = 1'b0;
            end
        end
        check("bp_all_accepted", 32'(accepted), 12);
        drain("bp");

        // Reset mid-operation with 3 commands queued and 2 in flight.
        bus.rsp_ready = 1'b0;
        rand_cmd();
        for (int c = 0; c < 15; c++) begin
            cycle(acc);
            if (acc) rand_cmd();
        end
        bus.rsp_ready = 1'b1;
        repeat (2) begin
            cycle(acc);
            if (acc) rand_cmd();
        end
        bus.rsp_ready = 1'b0;
        cycle(acc);
        check("pre_reset_busy", 32'(idle), 0);
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("midrst_rsp_data", 32'(bus.rsp_data), 0);
        check("midrst_rsp_tag", 32'(bus.rsp_tag), 0);
        check("midrst_alu_a", 32'(alu_a), 0);
        check("midrst_alu_b", 32'(alu_b), 0);
        check("midrst_alu_sel", 32'(alu_sel), 0);
        check("midrst_idle", 32'(idle), 1);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
        model.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        p0 = pops;
        bus.rsp_ready = 1'b1;
        set_cmd(8'h80, 8'h80, 0, 4'hA);
        cycle(acc);
        check("post_reset_accept", 32'(acc), 1);
        drain("post_reset");
        check("post_reset_single_rsp", 32'(pops - p0), 1);

        // Random traffic with random backpressure.
        accepted = 0;
        n = 0;
        rand_cmd();
        while (accepted < 40 && n < 400) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            cycle(acc);
            n++;
            if (acc) begin
                accepted++;
                if ($urandom_range(0, 3) == 0) bus.cmd_valid = 1'b0;
                else rand_cmd();
            end else if (!bus.cmd_valid) begin
                rand_cmd();
            end
        end
        check("rand_all_accepted", 32'(accepted), 40);
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
